// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_pkg
// Purpose  : Shared vending-machine definitions: controller state encoding,
//            coin codes, selection codes and product prices.
// Revision : 1.0 - initial release
// ============================================================================
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ACUM       = 3'd1,
        CONSULTA   = 3'd2,
        EVALUA     = 3'd3,
        ENTREGA    = 3'd4,
        DEVOLUCION = 3'd5
    } estado_t;

    localparam logic [1:0] c_MONEDA_1 = 2'b01;
    localparam logic [1:0] c_MONEDA_2 = 2'b10;

    localparam logic [1:0] c_SEL_A    = 2'b01;
    localparam logic [1:0] c_SEL_B    = 2'b10;

    localparam logic [3:0] c_PRECIO_A = 4'd5;
    localparam logic [3:0] c_PRECIO_B = 4'd6;

    // Credit units carried by a coin code; zero marks an invalid code.
    function automatic logic [3:0] valor_moneda(input logic [1:0] codigo);
        case (codigo)
            c_MONEDA_1: return 4'd1;
            c_MONEDA_2: return 4'd2;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic seleccion_valida(input logic [1:0] codigo);
        return (codigo == c_SEL_A) || (codigo == c_SEL_B);
    endfunction

endpackage : vending_pkg
`default_nettype wire

// File: rtl/temporizador_inactividad.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_inactividad
// Purpose  : Inactivity counter. Counts enabled cycles since the last clear
//            and flags expiry once TIMEOUT-1 cycles have elapsed.
// Revision : 1.0 - initial release
// ============================================================================
module temporizador_inactividad #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expira
);

    localparam int                   c_ANCHO  = $clog2(TIMEOUT);
    localparam logic [c_ANCHO-1:0]   c_ULTIMO = c_ANCHO'(TIMEOUT - 1);

    logic [c_ANCHO-1:0] r_cuenta;

    // Count enabled cycles, saturating at the expiry value so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cuenta <= '0;
        end else if (i_en && (r_cuenta != c_ULTIMO)) begin
            r_cuenta <= r_cuenta + c_ANCHO'(1);
        end
    end

    // Expiry is derived from the register only, so the consumer may feed
    // its enable back from logic that depends on this flag.
    assign o_expira = (r_cuenta == c_ULTIMO);

endmodule : temporizador_inactividad
`default_nettype wire

// File: rtl/controlador_venta.sv
`default_nettype none
// ============================================================================
// Module   : controlador_venta
// Purpose  : Vending transaction controller. Accumulates capped credit,
//            queries the pricing FSM, strobes dispense, returns change and
//            refunds credit on cancel or inactivity.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_venta
    import vending_pkg::*;
#(
    parameter int MAX_TOTAL = 8,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       moneda_valida,
    input  logic [1:0] moneda_valor,
    input  logic [1:0] boton_sel,
    input  logic       cancelar,
    output logic [3:0] total,
    output logic [1:0] seleccion,
    input  logic [1:0] producto,
    input  logic       listo,
    input  logic [1:0] cambio,
    output logic       entrega,
    output logic [1:0] producto_entregado,
    output logic       devuelve_moneda,
    output logic       moneda_rechazada,
    output logic       fondos_insuf,
    output logic       ocupado
);

    localparam logic [3:0] c_MAX = 4'(MAX_TOTAL);

    estado_t    r_estado, w_estado;
    logic [3:0] r_total,  w_total;
    logic [1:0] r_sel,    w_sel;
    logic [1:0] r_cambio, w_cambio;
    logic [3:0] r_cnt,    w_cnt;
    logic       r_entrega, w_entrega;
    logic [1:0] r_prod,    w_prod;
    logic       r_dev,     w_dev;
    logic       r_rech,    w_rech;
    logic       r_fondos,  w_fondos;
    logic       r_ocupado, w_ocupado;

    logic       w_acepta;
    logic [3:0] w_valor;
    logic [3:0] w_suma;
    logic       w_sel_ok;
    logic       w_expira;
    logic       w_tmr_clr;
    logic       w_tmr_en;

    assign w_valor  = valor_moneda(moneda_valor);
    assign w_suma   = r_total + w_valor;
    assign w_sel_ok = seleccion_valida(boton_sel);

    // Idle time only accrues while staying in ACUM without an accepted coin.
    assign w_tmr_clr = (r_estado != ACUM) || (w_estado != ACUM) || w_acepta;
    assign w_tmr_en  = !w_tmr_clr;

    temporizador_inactividad #(
        .TIMEOUT (TIMEOUT)
    ) u_temporizador (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expira (w_expira)
    );

    // Next state and next value of every registered output.
    always_comb begin
        w_estado  = r_estado;
        w_total   = r_total;
        w_sel     = r_sel;
        w_cambio  = r_cambio;
        w_cnt     = r_cnt;
        w_entrega = 1'b0;
        w_prod    = 2'b00;
        w_dev     = 1'b0;
        w_fondos  = 1'b0;
        w_acepta  = 1'b0;

        case (r_estado)
            IDLE: begin
                // Credit is zero here, so any valid coin fits under the cap.
                if (moneda_valida && (w_valor != 4'd0)) begin
                    w_total  = w_suma;
                    w_acepta = 1'b1;
                    w_estado = ACUM;
                end
            end
            ACUM: begin
                if (cancelar) begin
                    w_estado = DEVOLUCION;
                    w_cnt    = r_total;
                    w_dev    = 1'b1;
                end else if (w_sel_ok) begin
                    w_sel    = boton_sel;
                    w_estado = CONSULTA;
                end else if (moneda_valida && (w_valor != 4'd0) && (w_suma <= c_MAX)) begin
                    w_total  = w_suma;
                    w_acepta = 1'b1;
                end else if (w_expira) begin
                    w_estado = DEVOLUCION;
                    w_cnt    = r_total;
                    w_dev    = 1'b1;
                end
            end
            CONSULTA: begin
                w_estado = EVALUA;
            end
            EVALUA: begin
                w_sel = 2'b00;
                if (listo) begin
                    w_entrega = 1'b1;
                    w_prod    = producto;
                    w_cambio  = cambio;
                    w_estado  = ENTREGA;
                end else begin
                    w_fondos = 1'b1;
                    w_estado = ACUM;
                end
            end
            ENTREGA: begin
                w_total = 4'd0;
                if (r_cambio != 2'b00) begin
                    w_cnt    = {2'b00, r_cambio};
                    w_dev    = 1'b1;
                    w_estado = DEVOLUCION;
                end else begin
                    w_estado = IDLE;
                end
            end
            DEVOLUCION: begin
                // On a refund total tracks the coins still owed; after a
                // dispense it is already zero and stays there.
                w_total = (r_total != 4'd0) ? (r_total - 4'd1) : 4'd0;
                if (r_cnt > 4'd1) begin
                    w_cnt = r_cnt - 4'd1;
                    w_dev = 1'b1;
                end else begin
                    w_cnt    = 4'd0;
                    w_total  = 4'd0;
                    w_estado = IDLE;
                end
            end
            default: begin
                w_estado = IDLE;
                w_total  = 4'd0;
                w_sel    = 2'b00;
                w_cnt    = 4'd0;
            end
        endcase

        w_rech    = moneda_valida && !w_acepta;
        w_ocupado = (w_estado inside {CONSULTA, EVALUA, ENTREGA, DEVOLUCION});
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= IDLE;
            r_total   <= 4'd0;
            r_sel     <= 2'b00;
            r_cambio  <= 2'b00;
            r_cnt     <= 4'd0;
            r_entrega <= 1'b0;
            r_prod    <= 2'b00;
            r_dev     <= 1'b0;
            r_rech    <= 1'b0;
            r_fondos  <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_estado  <= w_estado;
            r_total   <= w_total;
            r_sel     <= w_sel;
            r_cambio  <= w_cambio;
            r_cnt     <= w_cnt;
            r_entrega <= w_entrega;
            r_prod    <= w_prod;
            r_dev     <= w_dev;
            r_rech    <= w_rech;
            r_fondos  <= w_fondos;
            r_ocupado <= w_ocupado;
        end
    end

    assign total              = r_total;
    assign seleccion          = r_sel;
    assign entrega            = r_entrega;
    assign producto_entregado = r_prod;
    assign devuelve_moneda    = r_dev;
    assign moneda_rechazada   = r_rech;
    assign fondos_insuf       = r_fondos;
    assign ocupado            = r_ocupado;

endmodule : controlador_venta
`default_nettype wire

// File: tb/tb_controlador_venta.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_venta
// Purpose  : Self-checking bench for controlador_venta with an attached
//            pricing FSM model and a transaction-level expected-output model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_venta;

    localparam int MAXT = 8;
    localparam int TOUT = 16;
    localparam int NS   = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       moneda_valida;
    logic [1:0] moneda_valor;
    logic [1:0] boton_sel;
    logic       cancelar;
    logic [3:0] total;
    logic [1:0] seleccion;
    logic [1:0] producto;
    logic       listo;
    logic [1:0] cambio;
    logic       entrega;
    logic [1:0] producto_entregado;
    logic       devuelve_moneda;
    logic       moneda_rechazada;
    logic       fondos_insuf;
    logic       ocupado;

    int n_cmp = 0;
    int n_err = 0;
    int n_dev = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    controlador_venta #(
        .MAX_TOTAL (MAXT),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .moneda_valida      (moneda_valida),
        .moneda_valor       (moneda_valor),
        .boton_sel          (boton_sel),
        .cancelar           (cancelar),
        .total              (total),
        .seleccion          (seleccion),
        .producto           (producto),
        .listo              (listo),
        .cambio             (cambio),
        .entrega            (entrega),
        .producto_entregado (producto_entregado),
        .devuelve_moneda    (devuelve_moneda),
        .moneda_rechazada   (moneda_rechazada),
        .fondos_insuf       (fondos_insuf),
        .ocupado            (ocupado)
    );

    // Registered pricing FSM: A costs 5, B costs 6.
    always @(posedge clk) begin
        if (rst) begin
            producto <= 2'b00; listo <= 1'b0; cambio <= 2'b00;
        end else if (seleccion == 2'b01 && total >= 4'd5) begin
            producto <= 2'b01; listo <= 1'b1; cambio <= 2'(total - 4'd5);
        end else if (seleccion == 2'b10 && total >= 4'd6) begin
            producto <= 2'b10; listo <= 1'b1; cambio <= 2'(total - 4'd6);
        end else begin
            producto <= 2'b00; listo <= 1'b0; cambio <= 2'b00;
        end
    end

    // Expected outputs per cycle; slot k holds the cycle after edge k.
    logic [3:0] e_tot [NS];
    logic [1:0] e_sel [NS];
    logic [1:0] e_pe  [NS];
    logic       e_ent [NS];
    logic       e_dev [NS];
    logic       e_rej [NS];
    logic       e_fi  [NS];
    logic       e_ocu [NS];

    int k      = 0;
    int credit = 0;
    int libre  = 0;
    int t_act  = 0;

    task automatic put(input int s, input int tt, input int sl, input bit en,
                       input int pe, input bit dv, input bit fi, input bit oc);
        e_tot[s] = 4'(tt); e_sel[s] = 2'(sl); e_ent[s] = en; e_pe[s] = 2'(pe);
        e_dev[s] = dv;     e_fi[s]  = fi;     e_ocu[s] = oc; e_rej[s] = 1'b0;
    endtask

    task automatic refund(input int s);
        for (int i = 0; i < credit; i++) put(s + i, credit - i, 0, 0, 0, 1, 0, 1);
        put(s + credit, 0, 0, 0, 0, 0, 0, 0);
        libre  = s + credit + 1;
        credit = 0;
    endtask

    task automatic choose(input int s, input int code);
        int price;
        int ch;
        price = (code == 1) ? 5 : 6;
        put(s,     credit, code, 0, 0, 0, 0, 1);
        put(s + 1, credit, code, 0, 0, 0, 0, 1);
        if (credit >= price) begin
            ch = credit - price;
            put(s + 2, credit, 0, 1, code, 0, 0, 1);
            for (int i = 0; i < ch; i++) put(s + 3 + i, 0, 0, 0, 0, 1, 0, 1);
            put(s + 3 + ch, 0, 0, 0, 0, 0, 0, 0);
            libre  = s + 4 + ch;
            credit = 0;
        end else begin
            put(s + 2, credit, 0, 0, 0, 0, 1, 0);
            libre = s + 3;
            t_act = s + 2;
        end
    endtask

    task automatic model_step();
        int v;
        bit rej;
        k++;
        v   = (moneda_valor == 2'b01) ? 1 : (moneda_valor == 2'b10) ? 2 : 0;
        rej = 1'b0;
        if (rst) begin
            credit = 0;
            libre  = k + 1;
            put(k, 0, 0, 0, 0, 0, 0, 0);
        end else if (k >= libre) begin
            if (credit == 0) begin
                if (moneda_valida && v != 0) begin credit = v; t_act = k; end
                else rej = moneda_valida;
                put(k, credit, 0, 0, 0, 0, 0, 0);
            end else if (cancelar) begin
                rej = moneda_valida;
                refund(k);
            end else if (boton_sel == 2'b01 || boton_sel == 2'b10) begin
                rej = moneda_valida;
                choose(k, int'(boton_sel));
            end else if (moneda_valida && v != 0 && credit + v <= MAXT) begin
                credit += v;
                t_act = k;
                put(k, credit, 0, 0, 0, 0, 0, 0);
            end else begin
                rej = moneda_valida;
                if (k - t_act >= TOUT) refund(k);
                else put(k, credit, 0, 0, 0, 0, 0, 0);
            end
        end else begin
            rej = moneda_valida;
        end
        e_rej[k] = rej;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @slot %0d t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (devuelve_moneda) n_dev++;
        if (chk_en) begin
            cmp("total",              int'(total),              int'(e_tot[k]));
            cmp("seleccion",          int'(seleccion),          int'(e_sel[k]));
            cmp("entrega",            int'(entrega),            int'(e_ent[k]));
            cmp("producto_entregado", int'(producto_entregado), int'(e_pe[k]));
            cmp("devuelve_moneda",    int'(devuelve_moneda),    int'(e_dev[k]));
            cmp("moneda_rechazada",   int'(moneda_rechazada),   int'(e_rej[k]));
            cmp("fondos_insuf",       int'(fondos_insuf),       int'(e_fi[k]));
            cmp("ocupado",            int'(ocupado),            int'(e_ocu[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic coin(input logic [1:0] code);
        moneda_valida = 1'b1; moneda_valor = code;
        tick();
        moneda_valida = 1'b0; moneda_valor = 2'b00;
    endtask

    task automatic press(input logic [1:0] s);
        boton_sel = s;
        tick();
        boton_sel = 2'b00;
    endtask

    task automatic cancel_req(input bit with_coin, input logic [1:0] code);
        cancelar = 1'b1; moneda_valida = with_coin; moneda_valor = code;
        tick();
        cancelar = 1'b0; moneda_valida = 1'b0; moneda_valor = 2'b00;
    endtask

    initial begin
        rst = 1'b1; moneda_valida = 1'b0; moneda_valor = 2'b00;
        boton_sel = 2'b00; cancelar = 1'b0;
        idle(2);
        chk_en = 1'b1;
        cmp("reset_total", int'(total), 0);
        cmp("reset_ocupado", int'(ocupado), 0);
        rst = 1'b0;
        idle(1);

        // Selection and cancel with no credit are ignored.
        press(2'b01);
        cancel_req(1'b0, 2'b00);
        cmp("idle_ignore_ocupado", int'(ocupado), 0);

        // 2+2+1, buy A: exact price.
        n_dev = 0;
        coin(2'b10); coin(2'b10); coin(2'b01);
        cmp("t1_total5", int'(total), 5);
        press(2'b01);
        idle(2);
        cmp("t1_entrega", int'(entrega), 1);
        cmp("t1_producto", int'(producto_entregado), 1);
        idle(2);
        cmp("t1_no_change", n_dev, 0);
        cmp("t1_idle_total", int'(total), 0);

        // 2+2+2+2, buy B: two coins of change.
        coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b10);
        cmp("t2_total8", int'(total), 8);
        n_dev = 0;
        press(2'b10);
        idle(2);
        cmp("t2_entrega", int'(entrega), 1);
        cmp("t2_producto", int'(producto_entregado), 2);
        idle(4);
        cmp("t2_change_count", n_dev, 2);
        cmp("t2_total0", int'(total), 0);

        // Credit 5, B refused; top up and retry.
        coin(2'b10); coin(2'b10); coin(2'b01);
        press(2'b10);
        idle(2);
        cmp("t3_fondos", int'(fondos_insuf), 1);
        cmp("t3_total_kept", int'(total), 5);
        cmp("t3_not_busy", int'(ocupado), 0);
        coin(2'b01);
        n_dev = 0;
        press(2'b10);
        idle(2);
        cmp("t3_entrega", int'(entrega), 1);
        idle(2);
        cmp("t3_no_change", n_dev, 0);

        // Credit 7: over-cap coin, invalid code, coin while busy.
        coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b01);
        coin(2'b10);
        cmp("t4_overcap_rej", int'(moneda_rechazada), 1);
        cmp("t4_total7", int'(total), 7);
        coin(2'b11);
        cmp("t4_code11_rej", int'(moneda_rechazada), 1);
        press(2'b01);
        coin(2'b01);
        cmp("t4_busy_rej", int'(moneda_rechazada), 1);
        cmp("t4_busy", int'(ocupado), 1);
        idle(5);
        cmp("t4_total0", int'(total), 0);

        // Credit 3 then idle until the automatic refund.
        n_dev = 0;
        coin(2'b10); coin(2'b01);
        idle(TOUT - 1);
        cmp("t5_no_early_refund", int'(devuelve_moneda), 0);
        tick();
        cmp("t5_refund_start", int'(devuelve_moneda), 1);
        cmp("t5_refund_total", int'(total), 3);
        idle(3);
        cmp("t5_refund_count", n_dev, 3);
        cmp("t5_back_idle", int'(ocupado), 0);

        // Cancel plus coin in the same cycle.
        coin(2'b10);
        cancel_req(1'b1, 2'b01);
        cmp("t5_cancel_coin_rej", int'(moneda_rechazada), 1);
        cmp("t5_cancel_total", int'(total), 2);
        idle(3);

        // Reset in the middle of a refund.
        coin(2'b10); coin(2'b10); coin(2'b10);
        cancel_req(1'b0, 2'b00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_dev = 0;
        cmp("t6_reset_dev", int'(devuelve_moneda), 0);
        cmp("t6_reset_total", int'(total), 0);
        idle(6);
        cmp("t6_no_more_strobes", n_dev, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_controlador_venta
`default_nettype wire

// File: doc/controlador_venta.md
# controlador_venta

Transaction controller for the vending machine. Accumulates inserted coins into a capped credit, presents `total`/`seleccion` to the registered pricing FSM, reads back `producto`/`listo`/`cambio`, issues a one-cycle dispense strobe and returns change or refunds one unit coin per cycle. Handles cancel and inactivity timeout. Sits between the coin/button front-end and the pricing FSM.

## Interface
- `MAX_TOTAL`, 8: credit cap in units; legal range 6..8, so change always fits 2 bits.
- `TIMEOUT`, 1000: idle cycles in ACUM before automatic refund; ≥ 2.
- `clk  in  1  single clock, rising edge`
- `rst  in  1  synchronous, active-high reset`
- `moneda_valida  in  1  coin-present strobe, one cycle per coin`
- `moneda_valor  in  2  01 = 1 unit, 10 = 2 units, 00/11 invalid`
- `boton_sel  in  2  01 = product A, 10 = product B, 00/11 = none`
- `cancelar  in  1  refund request`
- `total  out  4  credit presented to pricing FSM`
- `seleccion  out  2  selection presented to pricing FSM; 00 except in CONSULTA/EVALUA`
- `producto  in  2  from pricing FSM`
- `listo  in  1  from pricing FSM`
- `cambio  in  2  from pricing FSM`
- `entrega  out  1  one-cycle dispense strobe`
- `producto_entregado  out  2  product code, valid with `entrega`, else 00`
- `devuelve_moneda  out  1  one strobe per 1-unit coin returned`
- `moneda_rechazada  out  1  one-cycle strobe, coin not accepted`
- `fondos_insuf  out  1  one-cycle strobe, selection refused`
- `ocupado  out  1  high in CONSULTA, EVALUA, ENTREGA, DEVOLUCION`

## Operation
- All outputs registered. Reset: state IDLE, `total`=0, `seleccion`=00, every strobe 0, `producto_entregado`=00, `ocupado`=0, timeout and return counters 0. Reset mid-transaction drops credit without refund.
- IDLE: valid coin → add, go ACUM. Selection or cancel with zero credit ignored.
- ACUM: priority `cancelar` > valid `boton_sel` > coin. Cancel → DEVOLUCION with count=`total`. Selection → latch into `seleccion`, go CONSULTA. Coin accepted iff valid code and `total`+value ≤ MAX_TOTAL, else `moneda_rechazada`. Coin in the same cycle as cancel/selection is rejected.
- Timeout counter clears on entering ACUM and on every accepted coin, increments otherwise; reaching TIMEOUT−1 → DEVOLUCION with count=`total`.
- CONSULTA: one cycle, `seleccion`/`total` held stable.
- EVALUA: pricing outputs valid. `listo`=1 → latch `producto`, `cambio`; go ENTREGA. `listo`=0 → pulse `fondos_insuf`, clear `seleccion`, return to ACUM with credit kept, timeout cleared.
- ENTREGA: `entrega`=1, `producto_entregado`=latched code for one cycle; `total`←0. Latched `cambio`>0 → DEVOLUCION with count=`cambio`, else IDLE.
- DEVOLUCION: `devuelve_moneda`=1 every cycle, count decrements; leaves to IDLE the cycle after the final strobe with `total`=0. Refund path decrements `total` alongside.
- Any coin outside IDLE/ACUM is rejected. `cancelar`/`boton_sel` ignored outside IDLE/ACUM.

## Timing
- Selection sampled at edge E0 → CONSULTA, `seleccion` driven after E0. Pricing FSM registers at E1. Decision at E2 in EVALUA. `entrega` high in the cycle after E2: 3 cycles from selection to dispense.
- Change of N units: N consecutive `devuelve_moneda` cycles immediately after the `entrega` cycle.
- Refund of credit C: first strobe in the cycle after the cancel/timeout edge; C strobes back-to-back.
- Strobes never overlap except `moneda_rechazada`, which may coincide with any state.

## Structure
- Shared package `vending_pkg`: state encoding (IDLE, ACUM, CONSULTA, EVALUA, ENTREGA, DEVOLUCION), coin codes, selection codes, prices A=5, B=6. The pricing FSM takes prices from the same package.
- Sub-module `temporizador_inactividad`: parameterised TIMEOUT counter with clear/enable inputs and an expiry pulse.

## Test plan
- Coins 2,2,1, select A, pricing FSM attached → `total` 5, `entrega` with `producto_entregado`=01 3 cycles after select, no `devuelve_moneda`, back to IDLE.
- Coins 2,2,2,2, select B → `entrega` 10, then exactly 2 `devuelve_moneda` strobes, `total`=0.
- Credit 5, select B → `fondos_insuf` at cycle +2, state ACUM, `total` still 5. Then coin 1, select B → dispense, no change.
- Credit 7, insert 2 → `moneda_rechazada`, `total` 7. Code 11 → rejected. Coin during CONSULTA → rejected.
- Credit 3, hold inputs idle TIMEOUT cycles (TIMEOUT=16) → 3 `devuelve_moneda` strobes, IDLE. Cancel plus coin in the same cycle → coin rejected, full refund.
- Assert `rst` during DEVOLUCION → next cycle all outputs at reset values, no further strobes.
